writeback: RTL and testbench

- Producer side of the CPU's register-file write port.
- Accepts completed results from the memory stage and aligns/sign-extends load data.
- Drives the registered rd_en/rd_addr/rd_data write port one cycle later.
- Keeps a scoreboard of registers with writes still in flight, so decode stalls on RAW/WAW hazards instead of reading stale register-file contents.

---
 rtl/writeback.sv | 104 ++++++++++
 tb/tb_writeback.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/writeback.sv
// Writeback stage: aligns load data, drives the registered register-file write
// port, and tracks in-flight destination registers so decode can stall on
// RAW/WAW hazards.
module writeback #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned AW   = 5
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  issue_valid,
   input  logic [AW-1:0]         issue_rs1,
   input  logic [AW-1:0]         issue_rs2,
   input  logic [AW-1:0]         issue_rd,
   output logic                  issue_stall,
   input  logic                  res_valid,
   input  logic [AW-1:0]         res_rd,
   input  logic [XLEN-1:0]       res_data,
   input  logic                  res_load,
   input  logic [2:0]            res_funct3,
   input  logic [1:0]            res_byte,
   output logic                  rd_en,
   output logic [AW-1:0]         rd_addr,
   output logic [XLEN-1:0]       rd_data,
   output logic [(1<<AW)-1:0]    busy
);

   localparam int unsigned NReg = 1 << AW;

   logic            rd_en_q;
   logic [AW-1:0]   rd_addr_q;
   logic [XLEN-1:0] rd_data_q;
   logic [NReg-1:0] busy_q, busy_d;
   logic [XLEN-1:0] aligned;
   logic [7:0]      byte_sel;
   logic [15:0]     half_sel;
   logic            issue_accept;

   // Select the addressed byte/halfword and extend it according to the load type.
   always_comb begin
      byte_sel = 8'h00;
      unique case (res_byte)
         2'd0: byte_sel = res_data[7:0];
         2'd1: byte_sel = res_data[15:8];
         2'd2: byte_sel = res_data[23:16];
         2'd3: byte_sel = res_data[31:24];
         default: byte_sel = res_data[7:0];
      endcase
      // Halfword selection ignores the low address bit.
      half_sel = res_byte[1] ? res_data[31:16] : res_data[15:0];
      aligned  = res_data;
      if (res_load) begin
         case (res_funct3)
            3'b000: aligned = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            3'b100: aligned = {{(XLEN-8){1'b0}}, byte_sel};
            3'b001: aligned = {{(XLEN-16){half_sel[15]}}, half_sel};
            3'b101: aligned = {{(XLEN-16){1'b0}}, half_sel};
            default: aligned = res_data;
         endcase
      end
   end

   // Stall on any pending write to a source or the destination; no bypass.
   always_comb begin
      issue_stall  = issue_valid & (busy_q[issue_rs1] | busy_q[issue_rs2] | busy_q[issue_rd]);
      issue_accept = issue_valid & ~issue_stall & (issue_rd != '0);
   end

   // Scoreboard next state: clear on register-file write, then set on issue so set wins.
   always_comb begin
      busy_d = busy_q;
      if (rd_en_q) begin
         busy_d[rd_addr_q] = 1'b0;
      end
      if (issue_accept) begin
         busy_d[issue_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   // Write-port and scoreboard registers; reset drops any result captured this cycle.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
         rd_data_q <= '0;
         busy_q    <= '0;
      end else begin
         busy_q <= busy_d;
         if (res_valid) begin
            rd_en_q   <= (res_rd != '0);
            rd_addr_q <= res_rd;
            rd_data_q <= aligned;
         end else begin
            rd_en_q <= 1'b0;
         end
      end
   end

   assign rd_en   = rd_en_q;
   assign rd_addr = rd_addr_q;
   assign rd_data = rd_data_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_writeback.sv
// Directed bench for the writeback stage: reset, ALU and load writeback,
// scoreboard hazards and register-0 handling.
module tb_writeback;

   logic        clk;
   logic        resetn;
   logic        issue_valid;
   logic [4:0]  issue_rs1, issue_rs2, issue_rd;
   logic        issue_stall;
   logic        res_valid;
   logic [4:0]  res_rd;
   logic [31:0] res_data;
   logic        res_load;
   logic [2:0]  res_funct3;
   logic [1:0]  res_byte;
   logic        rd_en;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic [31:0] busy;

   int n_tests = 0;
   int n_fail  = 0;

   writeback #(.XLEN(32), .AW(5)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .issue_valid (issue_valid),
      .issue_rs1   (issue_rs1),
      .issue_rs2   (issue_rs2),
      .issue_rd    (issue_rd),
      .issue_stall (issue_stall),
      .res_valid   (res_valid),
      .res_rd      (res_rd),
      .res_data    (res_data),
      .res_load    (res_load),
      .res_funct3  (res_funct3),
      .res_byte    (res_byte),
      .rd_en       (rd_en),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle 1 time unit past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      resetn = 1'b0; res_valid = 1'b1; res_rd = 5'd5; res_data = 32'hDEADBEEF;
      step(); step(); step();
      n_tests++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en got %0b want 0", rd_en); end
      n_tests++; if (rd_addr !== 5'd0) begin n_fail++; $display("FAIL reset_rd_addr got %0d want 0", rd_addr); end
      n_tests++; if (rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
      n_tests++; if (busy !== 32'h0) begin n_fail++; $display("FAIL reset_busy got %h want 0", busy); end
      resetn = 1'b1; res_valid = 1'b0;
      step();
      n_tests++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL post_reset_rd_en got %0b want 0", rd_en); end
      n_tests++; if (busy !== 32'h0) begin n_fail++; $display("FAIL post_reset_busy got %h want 0", busy); end
   endtask

   task automatic test_alu();
      res_valid = 1'b1; res_rd = 5'd3; res_data = 32'h12345678; res_load = 1'b0;
      res_funct3 = 3'b000; res_byte = 2'd3;
      step();
      res_valid = 1'b0;
      n_tests++; if (rd_en !== 1'b1) begin n_fail++; $display("FAIL alu_rd_en got %0b want 1", rd_en); end
      n_tests++; if (rd_addr !== 5'd3) begin n_fail++; $display("FAIL alu_rd_addr got %0d want 3", rd_addr); end
      n_tests++; if (rd_data !== 32'h12345678) begin n_fail++; $display("FAIL alu_rd_data got %h want 12345678", rd_data); end
      step();
      n_tests++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL alu_rd_en_drop got %0b want 0", rd_en); end
      n_tests++; if (rd_data !== 32'h12345678) begin n_fail++; $display("FAIL alu_rd_data_hold got %h want 12345678", rd_data); end
   endtask

   task automatic test_load();
      logic [2:0]  f3  [6] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
      logic [1:0]  bo  [6] = '{2'd0, 2'd3, 2'd2, 2'd2, 2'd0, 2'd1};
      logic [31:0] exp [6] = '{32'h0000007F, 32'hFFFFFF80, 32'h000000F1,
                               32'hFFFF80F1, 32'h0000A27F, 32'h80F1A27F};
      for (int i = 0; i < 6; i++) begin
         res_valid = 1'b1; res_rd = 5'd1; res_data = 32'h80F1A27F; res_load = 1'b1;
         res_funct3 = f3[i]; res_byte = bo[i];
         step();
         n_tests++;
         if (rd_data !== exp[i]) begin
            n_fail++;
            $display("FAIL load_%0d f3=%b b=%0d got %h want %h", i, f3[i], bo[i], rd_data, exp[i]);
         end
      end
      res_valid = 1'b0; res_load = 1'b0;
      step();
   endtask

   task automatic test_raw();
      issue_valid = 1'b1; issue_rd = 5'd7; issue_rs1 = 5'd0; issue_rs2 = 5'd0;
      #1;
      n_tests++; if (issue_stall !== 1'b0) begin n_fail++; $display("FAIL raw_first_issue got %0b want 0", issue_stall); end
      step();
      n_tests++; if (busy[7] !== 1'b1) begin n_fail++; $display("FAIL raw_busy_set got %0b want 1", busy[7]); end
      issue_rs1 = 5'd7; issue_rd = 5'd8;
      #1;
      n_tests++; if (issue_stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall got %0b want 1", issue_stall); end
      step();
      res_valid = 1'b1; res_rd = 5'd7; res_data = 32'h000000AA;
      n_tests++; if (busy[8] !== 1'b0) begin n_fail++; $display("FAIL raw_stalled_no_set got %0b want 0", busy[8]); end
      step();
      res_valid = 1'b0;
      n_tests++; if (!(rd_en === 1'b1 && rd_addr === 5'd7)) begin n_fail++; $display("FAIL raw_write got en=%0b addr=%0d want en=1 addr=7", rd_en, rd_addr); end
      n_tests++; if (issue_stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall_during_write got %0b want 1", issue_stall); end
      step();
      n_tests++; if (issue_stall !== 1'b0) begin n_fail++; $display("FAIL raw_stall_release got %0b want 0", issue_stall); end
      n_tests++; if (busy[7] !== 1'b0) begin n_fail++; $display("FAIL raw_busy_clear got %0b want 0", busy[7]); end
      issue_valid = 1'b0; issue_rs1 = 5'd0; issue_rd = 5'd0;
      step();
   endtask

   task automatic test_set_clear();
      res_valid = 1'b1; res_rd = 5'd9; res_data = 32'h00000009; res_load = 1'b0;
      step();
      res_valid = 1'b0;
      issue_valid = 1'b1; issue_rd = 5'd9; issue_rs1 = 5'd0; issue_rs2 = 5'd0;
      #1;
      n_tests++; if (issue_stall !== 1'b0) begin n_fail++; $display("FAIL sc_issue got %0b want 0", issue_stall); end
      step();
      n_tests++; if (busy[9] !== 1'b1) begin n_fail++; $display("FAIL sc_set_wins got %0b want 1", busy[9]); end
      n_tests++; if (issue_stall !== 1'b1) begin n_fail++; $display("FAIL sc_waw_stall got %0b want 1", issue_stall); end
      issue_valid = 1'b0;
      #1;
      n_tests++; if (issue_stall !== 1'b0) begin n_fail++; $display("FAIL sc_invalid_no_stall got %0b want 0", issue_stall); end
      issue_rd = 5'd0;
      res_valid = 1'b1; res_rd = 5'd9;
      step();
      res_valid = 1'b0;
      step();
      n_tests++; if (busy !== 32'h0) begin n_fail++; $display("FAIL sc_drain got %h want 0", busy); end
   endtask

   task automatic test_x0();
      issue_valid = 1'b1; issue_rd = 5'd0; issue_rs1 = 5'd0; issue_rs2 = 5'd0;
      res_valid = 1'b1; res_rd = 5'd0; res_data = 32'hFFFFFFFF;
      #1;
      n_tests++; if (issue_stall !== 1'b0) begin n_fail++; $display("FAIL x0_stall got %0b want 0", issue_stall); end
      step();
      n_tests++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL x0_busy got %0b want 0", busy[0]); end
      n_tests++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL x0_rd_en got %0b want 0", rd_en); end
      n_tests++; if (issue_stall !== 1'b0) begin n_fail++; $display("FAIL x0_stall_after got %0b want 0", issue_stall); end
      issue_valid = 1'b0; res_valid = 1'b0;
      step();
   endtask

   initial begin
      resetn = 1'b0; issue_valid = 1'b0; issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0;
      res_valid = 1'b0; res_rd = '0; res_data = '0; res_load = 1'b0;
      res_funct3 = '0; res_byte = '0;
      #2;
      test_reset();
      test_alu();
      test_load();
      test_raw();
      test_set_clear();
      test_x0();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
